timer_clk_div: RTL



---
 rtl/timer_clk_div.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/timer_clk_div.sv
// -----------------------------------------------------------------------------
// timer_clk_div
//
// Clock-select prescaler for the timer. It turns sys_clk into a one-cycle
// count-enable pulse (tmr_tick) at sys_clk/2, /4, /8 or /16. The ratio is
// chosen by tmr_cks. The block is gated by tmr_en and re-phased by
// tmr_restart.
//
// Build option:
//   TIMER_CKS_SYNC_EN  When defined, a tmr_cks change made while running is
//                      held back (cks_pend=1) until the current period ends.
//                      The switch then happens on the wrap edge, so no
//                      period is ever truncated.
//                      When undefined, a tmr_cks change re-phases the divider
//                      on the next edge, as a restart would, and cks_pend is
//                      held at 0.
//
// Ports:
//   sys_clk      system clock
//   sys_rst      synchronous, active-high reset
//   tmr_en       enables the divider
//   tmr_cks      divide select: 00=/2, 01=/4, 10=/8, 11=/16
//   tmr_restart  one-cycle pulse that re-phases the divider
//   tmr_tick     registered count-enable pulse, one sys_clk wide
//   cks_act      divide select currently in effect
//   cks_pend     a tmr_cks change is waiting for the period to end
//   div_cnt      divider phase (debug and verification)
//
// DIV_W must be at least 4 so that div_cnt can reach 15.
// -----------------------------------------------------------------------------
module timer_clk_div #(
    parameter int DIV_W = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             tmr_en,
    input  logic [1:0]       tmr_cks,
    input  logic             tmr_restart,
    output logic             tmr_tick,
    output logic [1:0]       cks_act,
    output logic             cks_pend,
    output logic [DIV_W-1:0] div_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1
`ifdef TIMER_CKS_SYNC_EN
        , ST_PEND = 2'd2
`endif
    } state_t;

    state_t           state_reg, state_next;
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic             tick_reg, tick_next;
    logic [1:0]       cks_act_reg, cks_act_next;
    logic             cks_pend_reg, cks_pend_next;

    // A terminal-count comparator for each ratio. The one that belongs to
    // the select in effect marks the last phase of the period, N-1.
    logic [3:0] wrap_hit;
    logic       at_wrap;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wrap
            assign wrap_hit[gi] = (div_cnt_reg == DIV_W'((2 ** (gi + 1)) - 1));
        end
    endgenerate

    assign at_wrap = wrap_hit[cks_act_reg];

    // Next-state logic. The priority order is:
    //   disable > restart > cks change > normal count.
    // Reset has the highest priority and is handled in the register block.
    always_comb begin
        state_next    = state_reg;
        div_cnt_next  = div_cnt_reg;
        tick_next     = 1'b0;
        cks_act_next  = cks_act_reg;
        cks_pend_next = cks_pend_reg;

        if (state_reg == ST_IDLE) begin
            // Stopped. The select in effect tracks the register, so the
            // enable edge starts with whatever value is present then.
            div_cnt_next  = '0;
            cks_act_next  = tmr_cks;
            cks_pend_next = 1'b0;
            if (tmr_en) begin
                state_next = ST_RUN;
            end
        end else if (!tmr_en) begin
            // Disable wins over a coincident wrap, so no tick is emitted.
            state_next    = ST_IDLE;
            div_cnt_next  = '0;
            cks_act_next  = tmr_cks;
            cks_pend_next = 1'b0;
        end else if (tmr_restart) begin
            // Re-phase. Any queued select change is applied here as well.
            state_next    = ST_RUN;
            div_cnt_next  = '0;
            cks_act_next  = tmr_cks;
            cks_pend_next = 1'b0;
        end else begin
`ifdef TIMER_CKS_SYNC_EN
            if (at_wrap) begin
                // Period boundary. Take whatever select is present now, so
                // the last write wins. If tmr_cks has gone back to the old
                // value, the ratio simply stays the same.
                state_next    = ST_RUN;
                div_cnt_next  = '0;
                tick_next     = 1'b1;
                cks_act_next  = tmr_cks;
                cks_pend_next = 1'b0;
            end else begin
                div_cnt_next = div_cnt_reg + DIV_W'(1);
                if ((state_reg == ST_RUN) && (tmr_cks != cks_act_reg)) begin
                    state_next    = ST_PEND;
                    cks_pend_next = 1'b1;
                end
            end
`else
            if (tmr_cks != cks_act_reg) begin
                // An immediate switch behaves exactly like a restart.
                div_cnt_next = '0;
                cks_act_next = tmr_cks;
            end else if (at_wrap) begin
                div_cnt_next = '0;
                tick_next    = 1'b1;
            end else begin
                div_cnt_next = div_cnt_reg + DIV_W'(1);
            end
`endif
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg    <= ST_IDLE;
            div_cnt_reg  <= '0;
            tick_reg     <= 1'b0;
            cks_act_reg  <= 2'b00;
            cks_pend_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            div_cnt_reg  <= div_cnt_next;
            tick_reg     <= tick_next;
            cks_act_reg  <= cks_act_next;
            cks_pend_reg <= cks_pend_next;
        end
    end

    assign tmr_tick = tick_reg;
    assign cks_act  = cks_act_reg;
    assign cks_pend = cks_pend_reg;
    assign div_cnt  = div_cnt_reg;

endmodule
